// File: rtl/ones_divisible_by_3_det.sv
// ones_divisible_by_3_det
// Serial monitor that tracks how many '1' bits have arrived since reset, modulo 3.
// y is high whenever that count is a multiple of 3 (zero included).
// Moore machine: y depends only on the state register, never directly on in.

module ones_divisible_by_3_det (
   input  logic clk,
   input  logic rst,   // synchronous, active-low
   input  logic in,
   output logic y
);

   // State encodes (number of ones seen) mod 3; 2'b11 is unused.
   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10
   } state_t;

   state_t state_q;
   state_t state_d;

   // State register: reset wins over everything, so in is ignored while rst=0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a '1' advances the residue, a '0' holds it; the unused code recovers to S0.
   always_comb begin
      state_d = S0;
      case (state_q)
         S0:      state_d = in ? S1 : S0;
         S1:      state_d = in ? S2 : S1;
         S2:      state_d = in ? S0 : S2;
         default: state_d = S0;
      endcase
   end

   // Output decode from the registered state only.
   always_comb begin
      y = 1'b0;
      if (state_q == S0) begin
         y = 1'b1;
      end
   end

endmodule

// File: tb/tb_ones_divisible_by_3_det.sv
// Testbench for ones_divisible_by_3_det: directed sequences with hand-derived
// expectations, then random streams checked against a ones-counter model.

module tb_ones_divisible_by_3_det;

   logic clk;
   logic rst;
   logic in;
   logic y;

   int n_tests;
   int n_fail;
   int ones_cnt;   // reference: number of ones sampled since the last reset

   ones_divisible_by_3_det dut (
      .clk (clk),
      .rst (rst),
      .in  (in),
      .y   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: y=%b expected %b (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: y=%b", tag, obs);
      end
   endtask

   // Apply one bit on the falling edge, let the rising edge sample it, then update the model.
   task automatic drive(input logic rst_v, input logic in_v);
      @(negedge clk);
      rst = rst_v;
      in  = in_v;
      @(posedge clk);
      #1;
      if (!rst_v) ones_cnt = 0;
      else if (in_v) ones_cnt++;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b1);
      check("reset", y, 1'b1);
   endtask

   // Run n bits (LSB first from bits) and compare y with the expected vector (LSB first).
   task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] exp_y);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, bits[i]);
         check($sformatf("%s[%0d]", tag, i), y, exp_y[i]);
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      ones_cnt = 0;
      rst = 1'b0;
      in  = 1'b0;

      // Reset, then one idle zero: y must stay 1.
      do_reset();
      run_seq("idle0", 1, 16'b0, 16'b1);

      // Three ones: y = 0,0,1
      do_reset();
      run_seq("three1", 3, 16'b111, 16'b100);

      // Zeros hold: in = 1,0,0,1,0,1 -> y = 0,0,0,0,0,1
      do_reset();
      run_seq("zeros", 6, 16'b101001, 16'b100000);

      // Wrap-around: 7 ones -> y = 0,0,1,0,0,1,0, then two more ones reach S0 only after S1->S2->S0
      do_reset();
      run_seq("wrap", 7, 16'b1111111, 16'b0100100);
      run_seq("wrap_s1", 2, 16'b11, 16'b10);

      // Reset mid-operation with in=1 during reset
      do_reset();
      run_seq("mid_pre", 2, 16'b11, 16'b00);
      drive(1'b0, 1'b1);
      check("mid_rst", y, 1'b1);
      run_seq("mid_post", 3, 16'b111, 16'b100);

      // Random stream of 100 bits after reset, checked against the counter model
      do_reset();
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)));
         check($sformatf("rand[%0d] cnt=%0d", i, ones_cnt), y, 1'((ones_cnt % 3) == 0));
      end

      // Random stream with occasional resets
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
         check($sformatf("rrst[%0d] cnt=%0d", i, ones_cnt), y, 1'((ones_cnt % 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
